// File: rtl/route_sel_sequencer.sv
// Route table sequencer: per table entry, pops one FIFO word, drives the DEMUX/MUX
// selects from the entry, lets them settle, then strobes the downstream capture.
module route_sel_sequencer #(
    parameter  int unsigned NUM_ROUTES = 4,
    parameter  int unsigned SETTLE     = 2,
    parameter  int unsigned CFG_W      = 13,
    localparam int unsigned IDX_W      = (NUM_ROUTES > 1) ? $clog2(NUM_ROUTES) : 1
) (
    input  logic             inClock,
    input  logic             inReset,
    input  logic             inStart,
    input  logic             inStop,
    input  logic             inFifoEmpty,
    input  logic             inCfgWrite,
    input  logic [IDX_W-1:0] inCfgAddr,
    input  logic [CFG_W-1:0] inCfgData,
    output logic             outReadEnable,
    output logic [2:0]       outSEL1,
    output logic [2:0]       outSEL2,
    output logic [1:0]       outSEL6,
    output logic [1:0]       outSEL9,
    output logic [2:0]       outSEL15,
    output logic             outSample,
    output logic             outBusy,
    output logic             outDone
);

    localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

    typedef enum logic [2:0] {
        stIdle,
        stWait,
        stPop,
        stSettle,
        stSample,
        stDone
    } stateT;

    stateT            state;
    stateT            stateNext;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idxNext;
    logic [CNT_W-1:0] settleCnt;
    logic [CNT_W-1:0] settleCntNext;
    logic             selLoad;
    logic             selClear;
    logic             tableWe;
    logic [CFG_W-1:0] routeTable [NUM_ROUTES];
    logic [CFG_W-1:0] entry;

    assign entry = routeTable[idx];

    always_comb begin
        stateNext     = state;
        idxNext       = idx;
        settleCntNext = settleCnt;
        selLoad       = 1'b0;
        selClear      = 1'b0;
        // Table is only writable while idle; out-of-range addresses are ignored.
        tableWe       = (state == stIdle) && inCfgWrite && (32'(inCfgAddr) < NUM_ROUTES);

        if (inStop) begin
            stateNext     = stIdle;
            idxNext       = '0;
            settleCntNext = '0;
            selClear      = 1'b1;
        end else begin
            unique case (state)
                stIdle: begin
                    if (inStart) begin
                        stateNext = stWait;
                        idxNext   = '0;
                    end
                end
                stWait: begin
                    if (!inFifoEmpty) begin
                        stateNext     = stPop;
                        selLoad       = 1'b1;
                        settleCntNext = CNT_W'(SETTLE);
                    end
                end
                stPop: begin
                    stateNext = stSettle;
                end
                stSettle: begin
                    if (settleCnt <= CNT_W'(1)) begin
                        stateNext     = stSample;
                        settleCntNext = '0;
                    end else begin
                        settleCntNext = settleCnt - CNT_W'(1);
                    end
                end
                stSample: begin
                    if (idx == IDX_W'(NUM_ROUTES - 1)) begin
                        stateNext = stDone;
                    end else begin
                        stateNext = stWait;
                        idxNext   = idx + IDX_W'(1);
                    end
                end
                stDone: begin
                    stateNext = stIdle;
                end
                default: begin
                    stateNext = stIdle;
                end
            endcase
        end
    end

    // Outputs are registered copies decoded from the next state, so they change
    // on the same edge that enters the corresponding state.
    always_ff @(posedge inClock) begin
        if (inReset) begin
            state         <= stIdle;
            idx           <= '0;
            settleCnt     <= '0;
            outReadEnable <= 1'b0;
            outSample     <= 1'b0;
            outBusy       <= 1'b0;
            outDone       <= 1'b0;
            outSEL1       <= '0;
            outSEL2       <= '0;
            outSEL6       <= '0;
            outSEL9       <= '0;
            outSEL15      <= '0;
            for (int unsigned i = 0; i < NUM_ROUTES; i++) begin
                routeTable[i] <= '0;
            end
        end else begin
            state         <= stateNext;
            idx           <= idxNext;
            settleCnt     <= settleCntNext;
            outReadEnable <= (stateNext == stPop);
            outSample     <= (stateNext == stSample);
            outBusy       <= (stateNext != stIdle);
            outDone       <= (stateNext == stDone);

            if (tableWe) begin
                routeTable[inCfgAddr] <= inCfgData;
            end

            if (selClear) begin
                outSEL1  <= '0;
                outSEL2  <= '0;
                outSEL6  <= '0;
                outSEL9  <= '0;
                outSEL15 <= '0;
            end else if (selLoad) begin
                outSEL1  <= entry[2:0];
                outSEL2  <= entry[5:3];
                outSEL6  <= entry[7:6];
                outSEL9  <= entry[9:8];
                outSEL15 <= entry[12:10];
            end
        end
    end

endmodule

// File: tb/tb_route_sel_sequencer.sv
// Directed bench for route_sel_sequencer: table pass timing, FIFO stall, abort,
// busy-time writes/starts, same-cycle write+start and mid-pass reset.
module tb_route_sel_sequencer;

    logic        clk = 1'b0;
    logic        inReset = 1'b1;
    logic        inStart = 1'b0;
    logic        inStop = 1'b0;
    logic        inFifoEmpty = 1'b0;
    logic        inCfgWrite = 1'b0;
    logic [1:0]  inCfgAddr = '0;
    logic [12:0] inCfgData = '0;
    logic        outReadEnable;
    logic [2:0]  outSEL1;
    logic [2:0]  outSEL2;
    logic [1:0]  outSEL6;
    logic [1:0]  outSEL9;
    logic [2:0]  outSEL15;
    logic        outSample;
    logic        outBusy;
    logic        outDone;

    int vecCount = 0;
    int missCount = 0;

    route_sel_sequencer #(
        .NUM_ROUTES(4),
        .SETTLE(2),
        .CFG_W(13)
    ) dut (
        .inClock(clk),
        .inReset(inReset),
        .inStart(inStart),
        .inStop(inStop),
        .inFifoEmpty(inFifoEmpty),
        .inCfgWrite(inCfgWrite),
        .inCfgAddr(inCfgAddr),
        .inCfgData(inCfgData),
        .outReadEnable(outReadEnable),
        .outSEL1(outSEL1),
        .outSEL2(outSEL2),
        .outSEL6(outSEL6),
        .outSEL9(outSEL9),
        .outSEL15(outSEL15),
        .outSample(outSample),
        .outBusy(outBusy),
        .outDone(outDone)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input int got, input int exp);
        vecCount++;
        if (got != exp) begin
            missCount++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic checkSels(input string tag, input int s1, input int s2, input int s6,
                             input int s9, input int s15);
        checkVal({tag, ".SEL1"},  int'(outSEL1),  s1);
        checkVal({tag, ".SEL2"},  int'(outSEL2),  s2);
        checkVal({tag, ".SEL6"},  int'(outSEL6),  s6);
        checkVal({tag, ".SEL9"},  int'(outSEL9),  s9);
        checkVal({tag, ".SEL15"}, int'(outSEL15), s15);
    endtask

    // One active edge, then settle 1 time unit before sampling/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitDone(input string tag, input int maxCycles, output int samples);
        bit seen;
        seen = 1'b0;
        samples = 0;
        for (int i = 0; i < maxCycles && !seen; i++) begin
            tick();
            if (outSample) samples++;
            if (outDone) seen = 1'b1;
        end
        checkVal({tag, ".doneSeen"}, int'(seen), 1);
    endtask

    // Hand-decoded fields of 0x0001, 0x0A52, 0x1FFF, 0x0123.
    int expS1[4]  = '{1, 2, 7, 3};
    int expS2[4]  = '{0, 2, 7, 4};
    int expS6[4]  = '{0, 1, 3, 0};
    int expS9[4]  = '{0, 2, 3, 1};
    int expS15[4] = '{0, 2, 7, 0};
    logic [12:0] cfgVals[4] = '{13'h0001, 13'h0A52, 13'h1FFF, 13'h0123};

    initial begin
        int samples;

        tick();
        tick();
        inReset = 1'b0;
        checkVal("rst.re",     int'(outReadEnable), 0);
        checkVal("rst.sample", int'(outSample), 0);
        checkVal("rst.busy",   int'(outBusy), 0);
        checkVal("rst.done",   int'(outDone), 0);
        checkSels("rst", 0, 0, 0, 0, 0);

        // Load the table while idle.
        for (int a = 0; a < 4; a++) begin
            inCfgWrite = 1'b1;
            inCfgAddr  = 2'(a);
            inCfgData  = cfgVals[a];
            tick();
        end
        inCfgWrite = 1'b0;

        // Full pass: E0 is the start edge.
        inStart = 1'b1;
        tick();
        inStart = 1'b0;
        checkVal("p1.e0.busy", int'(outBusy), 1);
        checkVal("p1.e0.re",   int'(outReadEnable), 0);
        for (int e = 1; e <= 21; e++) begin
            tick();
            checkVal($sformatf("p1.e%0d.re", e), int'(outReadEnable),
                     int'(e == 1 || e == 6 || e == 11 || e == 16));
            checkVal($sformatf("p1.e%0d.sample", e), int'(outSample),
                     int'(e == 4 || e == 9 || e == 14 || e == 19));
            checkVal($sformatf("p1.e%0d.done", e), int'(outDone), int'(e == 20));
            checkVal($sformatf("p1.e%0d.busy", e), int'(outBusy), int'(e <= 20));
            if (e == 4 || e == 9 || e == 14 || e == 19) begin
                checkSels($sformatf("p1.e%0d", e), expS1[(e - 4) / 5], expS2[(e - 4) / 5],
                          expS6[(e - 4) / 5], expS9[(e - 4) / 5], expS15[(e - 4) / 5]);
            end
        end
        checkSels("p1.idleHold", 3, 4, 0, 1, 0);

        // FIFO empty stall while waiting for idx 2.
        inStart = 1'b1;
        tick();
        inStart = 1'b0;
        for (int e = 1; e <= 10; e++) tick();
        inFifoEmpty = 1'b1;
        for (int e = 11; e <= 17; e++) begin
            tick();
            checkVal($sformatf("stall.e%0d.re", e), int'(outReadEnable), 0);
            checkVal($sformatf("stall.e%0d.busy", e), int'(outBusy), 1);
        end
        checkSels("stall.hold", 2, 2, 1, 2, 2);
        inFifoEmpty = 1'b0;
        tick();
        checkVal("stall.popAfter", int'(outReadEnable), 1);
        checkSels("stall.pop", 7, 7, 3, 3, 7);
        waitDone("stall", 20, samples);
        checkVal("stall.samples", samples, 2);
        tick();
        checkVal("stall.idleBusy", int'(outBusy), 0);

        // Abort during SETTLE of idx 1 (pop at E6, SETTLE after E7).
        inStart = 1'b1;
        tick();
        inStart = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (e == 6) checkVal("abort.pop1", int'(outReadEnable), 1);
        end
        inStop = 1'b1;
        tick();
        inStop = 1'b0;
        checkVal("abort.busy",   int'(outBusy), 0);
        checkVal("abort.sample", int'(outSample), 0);
        checkVal("abort.done",   int'(outDone), 0);
        checkVal("abort.re",     int'(outReadEnable), 0);
        checkSels("abort", 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkVal("abort.stayIdle", int'(outBusy | outSample | outDone), 0);
        end

        // Restart from idx 0 with table intact; write + start while busy are dropped.
        inStart = 1'b1;
        tick();
        inStart = 1'b0;
        tick();
        checkVal("restart.re", int'(outReadEnable), 1);
        checkSels("restart.idx0", 1, 0, 0, 0, 0);
        tick();
        inCfgWrite = 1'b1;
        inCfgAddr  = 2'd2;
        inCfgData  = 13'h1555;
        inStart    = 1'b1;
        tick();
        inCfgWrite = 1'b0;
        inStart    = 1'b0;
        for (int e = 4; e <= 11; e++) tick();
        checkVal("busyWr.re", int'(outReadEnable), 1);
        checkSels("busyWr.idx2", 7, 7, 3, 3, 7);
        waitDone("busyWr", 20, samples);
        checkVal("busyWr.samples", samples, 2);
        for (int i = 0; i < 6; i++) begin
            tick();
            checkVal($sformatf("busyWr.noPass%0d", i), int'(outBusy | outReadEnable), 0);
        end

        // Same-cycle write + start: 0x0E07 -> SEL1=7 SEL2=0 SEL6=0 SEL9=2 SEL15=3.
        inCfgWrite = 1'b1;
        inCfgAddr  = 2'd0;
        inCfgData  = 13'h0E07;
        inStart    = 1'b1;
        tick();
        inCfgWrite = 1'b0;
        inStart    = 1'b0;
        tick();
        checkVal("wrStart.re", int'(outReadEnable), 1);
        checkSels("wrStart", 7, 0, 0, 2, 3);

        // Reset while in POP clears everything, including the table.
        inReset = 1'b1;
        tick();
        inReset = 1'b0;
        checkVal("midRst.re",     int'(outReadEnable), 0);
        checkVal("midRst.sample", int'(outSample), 0);
        checkVal("midRst.busy",   int'(outBusy), 0);
        checkVal("midRst.done",   int'(outDone), 0);
        checkSels("midRst", 0, 0, 0, 0, 0);
        inStart = 1'b1;
        tick();
        inStart = 1'b0;
        tick();
        checkVal("postRst.re", int'(outReadEnable), 1);
        checkSels("postRst.idx0", 0, 0, 0, 0, 0);
        waitDone("postRst", 30, samples);
        checkVal("postRst.samples", samples, 4);
        checkSels("postRst.last", 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
